// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
package cpu_mem_pkg;

    localparam int MEM_ADDR_W       = 32;
    localparam int MEM_DATA_W       = 32;
    localparam int DEFAULT_MAX_WAIT = 4;

    // Arbiter phases: waiting for a request, memory access open, response pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Which requester owns the transaction currently in flight.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Starvation guard for the unified memory arbiter: counts data grants taken
// while a fetch is pending and forces the next grant to fetch at MAX_WAIT.
// Only part of the build when ARB_STARVE_GUARD_EN is defined.
`ifdef ARB_STARVE_GUARD_EN
module arb_starve_counter
    import cpu_mem_pkg::*;
#(
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic d_gnt,
    input  logic if_gnt,
    output logic force_if
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;

    // Saturating count of data wins over a pending fetch; a fetch grant clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 4'd0;
        end else if (if_gnt) begin
            wait_cnt <= 4'd0;
        end else if (d_gnt && if_req && (wait_cnt != MAX_CNT)) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign force_if = if_req && (wait_cnt == MAX_CNT);

endmodule
`endif

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and the data
// load/store path. One access in flight; data wins unless the starvation
// guard (ARB_STARVE_GUARD_EN) forces a pending fetch through.
module unified_mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W   = MEM_ADDR_W,
    parameter int DATA_W   = MEM_DATA_W,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);

    localparam int BE_W = DATA_W / 8;

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_max_wait_range
        $error("unified_mem_arbiter: MAX_WAIT must be within 1..15");
    end

    arb_state_t        state, next_state;
    owner_t            owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] rdata_q;
    logic              grant_if, grant_d, force_if;

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_counter #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .d_gnt    (grant_d),
        .if_gnt   (grant_if),
        .force_if (force_if)
    );
`else
    // Strict data priority: fetch only wins when no data request is present.
    assign force_if = 1'b0;
`endif

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Arbitration and phase sequencing; grants exist only in IDLE, out of reset.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no latch is inferred.
        next_state = state;
        grant_if   = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (!reset) begin
                    if (if_req && (force_if || !d_req)) begin
                        grant_if = 1'b1;
                    end else if (d_req) begin
                        grant_d = 1'b1;
                    end
                end
                if (grant_if || grant_d) begin
                    next_state = XFER;
                end
            end
            XFER:    if (mem_ack) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Capture the winner's request at grant and the read data at completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= OWN_IF;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (grant_if) begin
                owner_q <= OWN_IF;
                addr_q  <= if_addr;
                we_q    <= 1'b0;
                wdata_q <= '0;
                be_q    <= '1;
            end else if (grant_d) begin
                owner_q <= OWN_D;
                addr_q  <= d_addr;
                we_q    <= d_we;
                wdata_q <= d_we ? d_wdata : '0;
                be_q    <= d_we ? d_be : '1;
            end
            if (state == XFER && mem_ack) begin
                rdata_q <= we_q ? '0 : mem_rdata;
            end
        end
    end

    assign if_gnt    = grant_if;
    assign d_gnt     = grant_d;

    assign mem_req   = (state == XFER);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = mem_req ? addr_q  : '0;
    assign mem_wdata = mem_req ? wdata_q : '0;
    assign mem_be    = mem_req ? be_q    : '0;

    assign if_rvalid = (state == RESP) && (owner_q == OWN_IF);
    assign d_rvalid  = (state == RESP) && (owner_q == OWN_D);
    assign if_rdata  = if_rvalid ? rdata_q : '0;
    assign d_rdata   = d_rvalid  ? rdata_q : '0;

    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: a transaction-level model checks every cycle,
// directed sequences add literal expectations. Honours ARB_STARVE_GUARD_EN.
module tb_unified_mem_arbiter;
    import cpu_mem_pkg::*;

    localparam int MAXW = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk, reset;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic        mem_req, mem_we, mem_ack, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Memory contents as seen by the responder.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory responder: acks after wait_cfg idle cycles; can assert stray acks.
    int   wait_cfg     = 0;
    logic spurious_ack = 1'b0;
    int   left         = 0;
    bit   in_acc       = 1'b0;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_req === 1'b1) begin
                if (!in_acc) begin
                    in_acc = 1'b1;
                    left   = wait_cfg;
                end
                if (left == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                    in_acc    = 1'b0;
                end else begin
                    left--;
                    mem_ack   = 1'b0;
                    mem_rdata = '0;
                end
            end else begin
                in_acc    = 1'b0;
                mem_ack   = spurious_ack;
                mem_rdata = spurious_ack ? 32'hBAD0_BAD0 : '0;
            end
        end
    end

    // Transaction-level reference: one access at a time, each either waiting for
    // its memory ack or delivering its single response.
    typedef struct packed {
        logic        is_if;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    txn_t        m_txn;
    bit          m_inflight = 1'b0;
    bit          m_resp     = 1'b0;
    logic [31:0] m_rdata    = '0;
    int          m_starve   = 0;

    always @(negedge clk) begin : model
        logic want_if, want_d, e_ifv, e_dv, e_mreq, e_busy;
        want_if = 1'b0; want_d = 1'b0;
        e_ifv = 1'b0; e_dv = 1'b0; e_mreq = 1'b0; e_busy = 1'b0;
        if (reset) begin
            m_inflight = 1'b0;
            m_resp     = 1'b0;
            m_starve   = 0;
            check("reset_ctrl", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we, busy, mem_be}, '0);
            check("reset_rdata", {if_rdata, d_rdata}, '0);
            check("reset_mem_bus", {mem_addr, mem_wdata}, '0);
        end else begin
            if (m_resp) begin
                e_busy = 1'b1;
                e_ifv  = m_txn.is_if;
                e_dv   = !m_txn.is_if;
            end else if (m_inflight) begin
                e_busy = 1'b1;
                e_mreq = 1'b1;
            end else begin
                want_if = if_req && (!d_req || (GUARD && m_starve >= MAXW));
                want_d  = !want_if && d_req;
            end
            check("ctrl", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, busy},
                          {want_if, want_d, e_ifv, e_dv, e_mreq, e_busy});
            if (e_ifv) check("if_rdata", if_rdata, m_rdata);
            if (e_dv)  check("d_rdata", d_rdata, m_rdata);
            if (e_mreq) begin
                check("mem_bus", {mem_we, mem_addr, mem_be},
                      {m_txn.we, m_txn.addr, m_txn.we ? m_txn.be : 4'hF});
                if (m_txn.we) check("mem_wdata", mem_wdata, m_txn.wdata);
            end

            if (m_resp) begin
                m_resp = 1'b0;
            end else if (m_inflight) begin
                if (mem_ack === 1'b1) begin
                    m_inflight = 1'b0;
                    m_resp     = 1'b1;
                    m_rdata    = m_txn.we ? 32'h0 : mem_rdata;
                end
            end else if (want_if) begin
                m_txn.is_if = 1'b1; m_txn.we = 1'b0; m_txn.addr = if_addr;
                m_txn.wdata = '0;   m_txn.be = 4'hF;
                m_inflight  = 1'b1;
                m_starve    = 0;
            end else if (want_d) begin
                m_txn.is_if = 1'b0; m_txn.we = d_we; m_txn.addr = d_addr;
                m_txn.wdata = d_wdata; m_txn.be = d_be;
                m_inflight  = 1'b1;
                if (if_req && m_starve < MAXW) m_starve++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic if_access(input logic [31:0] a, output int gcyc);
        if_req = 1'b1; if_addr = a; gcyc = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (if_gnt) begin gcyc = cyc; break; end
        end
        if (gcyc < 0) check("if_gnt_timeout", if_gnt, 1);
        tick();
        if_req = 1'b0;
    endtask

    task automatic d_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] be, output int gcyc);
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be; gcyc = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (d_gnt) begin gcyc = cyc; break; end
        end
        if (gcyc < 0) check("d_gnt_timeout", d_gnt, 1);
        tick();
        d_req = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("idle_timeout", busy, 0);
        tick();
    endtask

    int ic, dc, n, k;

    initial begin
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_mem_req", mem_req, 0);
        tick();
        reset = 1'b0;
        tick();

        // 1: single fetch, zero-wait memory.
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        check("t1_if_gnt_c0", if_gnt, 1);
        tick();
        if_req = 1'b0;
        @(negedge clk);
        check("t1_mem_c1", {mem_req, mem_ack, mem_addr, mem_be}, {1'b1, 1'b1, 32'h10, 4'hF});
        @(negedge clk);
        check("t1_rvalid_c2", {if_rvalid, if_rdata}, {1'b1, 32'h0050_0093});
        @(negedge clk);
        check("t1_idle_c3", busy, 0);
        tick();

        // 2: simultaneous requests, data first, fetch right after the response.
        fork
            if_access(32'h100, ic);
            d_access(1'b0, 32'h200, 32'h0, 4'hF, dc);
        join
        check("t2_d_first", dc < ic, 1);
        check("t2_if_gap", ic - dc, 3);
        wait_idle();

        // 3: byte-masked store with three memory wait cycles.
        wait_cfg = 3;
        d_access(1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0011, dc);
        n = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (!mem_req) break;
            n++;
            check("t3_mem_be", mem_be, 4'b0011);
        end
        check("t3_be_cycles", n, 4);
        check("t3_store_resp", {d_rvalid, d_rdata}, {1'b1, 32'h0});
        wait_cfg = 0;
        wait_idle();

        // 4: both requesters held high from a clean reset.
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h400;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'hF;
        k = 0;
        for (int j = 0; j < 200; j++) begin
            @(negedge clk);
            if (if_gnt || d_gnt) begin
                check("t4_grant_is_if", if_gnt, GUARD && (k % 5 == 4));
                k++;
                if (k == 10) break;
            end
        end
        check("t4_grant_count", k, 10);
        tick();
        if_req = 1'b0; d_req = 1'b0;
        wait_idle();

        // 5: reset in the middle of a slow load, then a normal access.
        wait_cfg = 5;
        d_access(1'b0, 32'h500, 32'h0, 4'hF, dc);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("t5_reset_mid_xfer", {mem_req, busy, d_rvalid}, 3'b000);
        tick();
        d_req = 1'b1; d_addr = 32'h600;
        @(negedge clk);
        check("t5_gnt_gated", d_gnt, 0);
        tick();
        reset = 1'b0;
        wait_cfg = 0;
        d_access(1'b0, 32'h600, 32'h0, 4'hF, dc);
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (d_rvalid) break;
        end
        check("t5_after_reset_resp", {d_rvalid, d_rdata}, {1'b1, mem_word(32'h600)});
        wait_idle();

        // 6: stray acks while idle and during the response.
        spurious_ack = 1'b1;
        repeat (3) tick();
        if_access(32'h20, ic);
        n = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (if_rvalid || d_rvalid) n++;
        end
        check("t6_single_rvalid", n, 1);
        spurious_ack = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
